// File: rtl/ddr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_wr_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4 DDR write port between
//            NUM_REQ per-MRMAC-port ingress write masters. A grant is taken on
//            an AW request and held for the whole burst, until both the AW
//            handshake and the W beat carrying wlast have completed. The DDR
//            side ID is {grant index, requester AWID} so B responses can be
//            routed back to the requester that issued the burst.
// Ports    : clk, rst            - single clock, async active-high reset
//            s_aw*/s_w*          - packed per-requester AW/W channels
//                                  (requester i at slice [i*W +: W])
//            s_b*                - B channel; bid/bresp shared, bvalid/bready
//                                  per requester
//            m_axi_*             - AXI4 write master towards the DDR controller
//            grant_idx, busy     - debug: current grantee, high during a burst
//            burst_cnt           - (ARB_STATS_EN only) 32-bit completed-burst
//                                  counter per requester
// Options  : `define ARB_STATS_EN adds burst_cnt and its counters.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int M_ID_WIDTH = ID_WIDTH + IDX_W
) (
  input  logic                             clk,
  input  logic                             rst,
  // requester-side AW
  input  logic [NUM_REQ*ID_WIDTH-1:0]      s_awid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_awaddr,
  input  logic [NUM_REQ*8-1:0]             s_awlen,
  input  logic [NUM_REQ*3-1:0]             s_awsize,
  input  logic [NUM_REQ*2-1:0]             s_awburst,
  input  logic [NUM_REQ-1:0]               s_awvalid,
  output logic [NUM_REQ-1:0]               s_awready,
  // requester-side W
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]               s_wlast,
  input  logic [NUM_REQ-1:0]               s_wvalid,
  output logic [NUM_REQ-1:0]               s_wready,
  // requester-side B
  output logic [ID_WIDTH-1:0]              s_bid,
  output logic [1:0]                       s_bresp,
  output logic [NUM_REQ-1:0]               s_bvalid,
  input  logic [NUM_REQ-1:0]               s_bready,
  // DDR-side AW
  output logic [M_ID_WIDTH-1:0]            m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  // DDR-side W
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]          m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  // DDR-side B
  input  logic [M_ID_WIDTH-1:0]            m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]            burst_cnt,
`endif
  // debug
  output logic [IDX_W-1:0]                 grant_idx,
  output logic                             busy
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic             burst_end;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  logic [ID_WIDTH-1:0]   g_awid;
  logic [ADDR_WIDTH-1:0] g_awaddr;
  logic [7:0]            g_awlen;
  logic [2:0]            g_awsize;
  logic [1:0]            g_awburst;
  logic                  g_awvalid;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic [STRB_W-1:0]     g_wstrb;
  logic                  g_wlast;
  logic                  g_wvalid;

  logic             in_burst;
  logic             awready_g;
  logic             wready_g;
  logic             aw_hs;
  logic             w_last_hs;
  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] b_idx;

  assign in_burst = (state_q == S_BURST);

  // Round-robin pick: first asserted awvalid at or after rr_ptr, wrapping.
  always_comb begin : p_pick
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_found && s_awvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Grantee mux for the AW/W payload and valids.
  always_comb begin : p_mux
    g_awid    = '0;
    g_awaddr  = '0;
    g_awlen   = '0;
    g_awsize  = '0;
    g_awburst = '0;
    g_awvalid = 1'b0;
    g_wdata   = '0;
    g_wstrb   = '0;
    g_wlast   = 1'b0;
    g_wvalid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        g_awid    = s_awid[i*ID_WIDTH +: ID_WIDTH];
        g_awaddr  = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_awlen   = s_awlen[i*8 +: 8];
        g_awsize  = s_awsize[i*3 +: 3];
        g_awburst = s_awburst[i*2 +: 2];
        g_awvalid = s_awvalid[i];
        g_wdata   = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_wstrb   = s_wstrb[i*STRB_W +: STRB_W];
        g_wlast   = s_wlast[i];
        g_wvalid  = s_wvalid[i];
      end
    end
  end

  // AW and W are independent: once the grant is taken, W beats may pass
  // before the AW handshake. Each channel closes itself once done.
  assign m_axi_awvalid = in_burst & g_awvalid & ~aw_done_q;
  assign awready_g     = in_burst & m_axi_awready & ~aw_done_q;
  assign m_axi_wvalid  = in_burst & g_wvalid & ~w_done_q;
  assign wready_g      = in_burst & m_axi_wready & ~w_done_q;

  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_last_hs = m_axi_wvalid & m_axi_wready & g_wlast;

  always_comb begin : p_ready
    s_awready = '0;
    s_wready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        s_awready[i] = awready_g;
        s_wready[i]  = wready_g;
      end
    end
  end

  // With a single requester there is no real index; the ID bit is tied low.
  if (NUM_REQ == 1) begin : g_idx_tied
    assign id_idx = '0;
  end else begin : g_idx_grant
    assign id_idx = grant_q;
  end

  assign m_axi_awid    = {id_idx, g_awid};
  assign m_axi_awaddr  = g_awaddr;
  assign m_axi_awlen   = g_awlen;
  assign m_axi_awsize  = g_awsize;
  assign m_axi_awburst = g_awburst;
  assign m_axi_wdata   = g_wdata;
  assign m_axi_wstrb   = g_wstrb;
  assign m_axi_wlast   = g_wlast;

  // FSM next state
  always_comb begin : p_next
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    burst_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d   = S_BURST;
          grant_d   = pick_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_BURST: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_last_hs;
        // Covers both channels finishing in the same cycle.
        if (aw_done_d && w_done_d) begin
          burst_end = 1'b1;
          state_d   = S_IDLE;
          rr_ptr_d  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // B routing: the top IDX_W bits of BID select the requester. An index
  // with no requester behind it is accepted and discarded.
  assign b_idx   = m_axi_bid[M_ID_WIDTH-1 -: IDX_W];
  assign s_bid   = m_axi_bid[ID_WIDTH-1:0];
  assign s_bresp = m_axi_bresp;

  always_comb begin : p_bresp
    s_bvalid     = '0;
    m_axi_bready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (b_idx == IDX_W'(i)) begin
        s_bvalid[i]  = m_axi_bvalid;
        m_axi_bready = s_bready[i];
      end
    end
  end

`ifdef ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (burst_end && (grant_q == IDX_W'(gi))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign burst_cnt[gi*32 +: 32] = cnt_q;
  end
`endif

  assign grant_idx = grant_q;
  assign busy      = in_burst;

endmodule
`default_nettype wire

// File: tb/tb_ddr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_wr_arbiter
// Purpose  : Directed self-checking bench for ddr_wr_arbiter (NUM_REQ=2,
//            DATA_WIDTH=32): reset state, single burst, round-robin pointer,
//            W ahead of AW, W backpressure, B routing, contention order and
//            asynchronous reset mid-burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_wr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int XW = 1;
  localparam int MW = IW + XW;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  logic [N*IW-1:0] s_awid;
  logic [N*AW-1:0] s_awaddr;
  logic [N*8-1:0]  s_awlen;
  logic [N*3-1:0]  s_awsize;
  logic [N*2-1:0]  s_awburst;
  logic [N-1:0]    s_awvalid;
  logic [N-1:0]    s_awready;
  logic [N*DW-1:0] s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_wlast;
  logic [N-1:0]    s_wvalid;
  logic [N-1:0]    s_wready;
  logic [IW-1:0]   s_bid;
  logic [1:0]      s_bresp;
  logic [N-1:0]    s_bvalid;
  logic [N-1:0]    s_bready;
  logic [MW-1:0]   m_axi_awid;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [MW-1:0]   m_axi_bid;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [XW-1:0]   grant_idx;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_wr_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_awid       (s_awid),
    .s_awaddr     (s_awaddr),
    .s_awlen      (s_awlen),
    .s_awsize     (s_awsize),
    .s_awburst    (s_awburst),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_wlast      (s_wlast),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_bid        (s_bid),
    .s_bresp      (s_bresp),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .m_axi_awid   (m_axi_awid),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awlen  (m_axi_awlen),
    .m_axi_awsize (m_axi_awsize),
    .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wlast  (m_axi_wlast),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bid    (m_axi_bid),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .grant_idx    (grant_idx),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leave the task 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int seen;
    int g;
    logic [MW-1:0] exp_id;

    rst           = 1'b1;
    s_awid        = '0;
    s_awaddr      = '0;
    s_awlen       = '0;
    s_awsize      = '0;
    s_awburst     = '0;
    s_awvalid     = '0;
    s_wdata       = '0;
    s_wstrb       = '1;
    s_wlast       = '0;
    s_wvalid      = '0;
    s_bready      = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bid     = '0;
    m_axi_bresp   = '0;
    m_axi_bvalid  = 1'b0;

    // ---- reset state, with requests and readies pushing against it ----
    repeat (2) tick();
    s_awvalid     = 2'b11;
    s_wvalid      = 2'b11;
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    #1;
    chk("rst_busy",    busy,          1'b0);
    chk("rst_grant",   grant_idx,     1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_wvalid",  m_axi_wvalid,  1'b0);
    chk("rst_awready", s_awready,     2'b00);
    chk("rst_wready",  s_wready,      2'b00);
    s_awvalid = '0;
    s_wvalid  = '0;
    tick();
    rst = 1'b0;
    tick();

    // ---- single burst, requester 0, awlen 3, AW and W0 together ----
    s_awid[3:0]    = 4'h3;
    s_awaddr[31:0] = 32'h0000_1000;
    s_awlen[7:0]   = 8'd3;
    s_awsize[2:0]  = 3'd2;
    s_awburst[1:0] = 2'b01;
    s_awvalid[0]   = 1'b1;
    s_wvalid[0]    = 1'b1;
    s_wdata[31:0]  = 32'hA0;
    #1;
    chk("t1_pregrant_busy",   busy,     1'b0);
    chk("t1_pregrant_wready", s_wready, 2'b00);
    tick();
    #1;
    chk("t1_busy",    busy,          1'b1);
    chk("t1_grant",   grant_idx,     1'b0);
    chk("t1_awvalid", m_axi_awvalid, 1'b1);
    chk("t1_awid",    m_axi_awid,    5'h03);
    chk("t1_awaddr",  m_axi_awaddr,  32'h1000);
    chk("t1_awlen",   m_axi_awlen,   8'd3);
    chk("t1_awready", s_awready,     2'b01);
    chk("t1_wready",  s_wready,      2'b01);
    chk("t1_wdata0",  m_axi_wdata,   32'hA0);
    tick();
    s_awvalid[0]  = 1'b0;
    s_wdata[31:0] = 32'hA1;
    #1;
    chk("t1_aw_closed", m_axi_awvalid, 1'b0);
    chk("t1_wdata1",    m_axi_wdata,   32'hA1);
    chk("t1_wlast1",    m_axi_wlast,   1'b0);
    tick();
    s_wdata[31:0] = 32'hA2;
    tick();
    s_wdata[31:0] = 32'hA3;
    s_wlast[0]    = 1'b1;
    #1;
    chk("t1_wlast3", m_axi_wlast, 1'b1);
    chk("t1_busy3",  busy,        1'b1);
    tick();
    s_wvalid[0] = 1'b0;
    s_wlast[0]  = 1'b0;
    #1;
    chk("t1_idle",        busy,     1'b0);
    chk("t1_idle_wready", s_wready, 2'b00);

    // ---- rr_ptr=1: both request, requester 1 wins; W ahead of AW ----
    s_awid[3:0]     = 4'h2;
    s_awaddr[31:0]  = 32'h0000_2000;
    s_awlen[7:0]    = 8'd7;
    s_awid[7:4]     = 4'h9;
    s_awaddr[63:32] = 32'h0000_3000;
    s_awlen[15:8]   = 8'd1;
    s_awsize[5:3]   = 3'd2;
    s_awburst[3:2]  = 2'b01;
    s_awvalid       = 2'b11;
    s_wvalid[1]     = 1'b1;
    s_wdata[63:32]  = 32'hB0;
    m_axi_awready   = 1'b0;
    tick();
    #1;
    chk("t2_grant",   grant_idx,    1'b1);
    chk("t2_awid",    m_axi_awid,   5'h19);
    chk("t2_awaddr",  m_axi_awaddr, 32'h3000);
    chk("t2_awready", s_awready,    2'b00);
    chk("t2_wready",  s_wready,     2'b10);
    chk("t2_wdata0",  m_axi_wdata,  32'hB0);
    tick();
    s_wdata[63:32] = 32'hB1;
    s_wlast[1]     = 1'b1;
    #1;
    chk("t2_wlast", m_axi_wlast, 1'b1);
    tick();
    s_wvalid[1] = 1'b0;
    s_wlast[1]  = 1'b0;
    #1;
    chk("t2_wait_busy",    busy,          1'b1);
    chk("t2_wait_wready",  s_wready,      2'b00);
    chk("t2_wait_awvalid", m_axi_awvalid, 1'b1);
    repeat (2) tick();
    #1;
    chk("t2_still_busy", busy, 1'b1);
    m_axi_awready = 1'b1;
    #1;
    chk("t2_awready_on", s_awready, 2'b10);
    tick();
    s_awvalid[1] = 1'b0;
    #1;
    chk("t2_idle", busy, 1'b0);

    // ---- requester 0, awlen 7, wready toggling 1,0,1,0 ----
    s_wvalid[0]   = 1'b1;
    s_wdata[31:0] = 32'hC000_0000;
    m_axi_wready  = 1'b1;
    tick();
    #1;
    chk("t3_grant",  grant_idx,    1'b0);
    chk("t3_awid",   m_axi_awid,   5'h02);
    chk("t3_awaddr", m_axi_awaddr, 32'h2000);
    chk("t3_awlen",  m_axi_awlen,  8'd7);
    b    = 0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && b < 8; cyc++) begin
      m_axi_wready  = (cyc % 2 == 0);
      s_wdata[31:0] = 32'hC000_0000 + b;
      s_wlast[0]    = (b == 7);
      #1;
      if (m_axi_wready) begin
        chk("t3_wdata", m_axi_wdata, 32'hC000_0000 + b);
        chk("t3_wlast", m_axi_wlast, (b == 7));
      end else begin
        chk("t3_stall_wready", s_wready, 2'b00);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        seen++;
        b++;
      end
      tick();
      s_awvalid[0] = 1'b0;
    end
    s_wvalid[0]  = 1'b0;
    s_wlast[0]   = 1'b0;
    m_axi_wready = 1'b1;
    #1;
    chk("t3_beats", seen, 8);
    chk("t3_idle",  busy, 1'b0);

    // ---- B routing ----
    m_axi_bid    = 5'h15;
    m_axi_bresp  = 2'b10;
    m_axi_bvalid = 1'b1;
    s_bready     = 2'b10;
    #1;
    chk("b_valid1", s_bvalid,     2'b10);
    chk("b_bid",    s_bid,        4'h5);
    chk("b_bresp",  s_bresp,      2'b10);
    chk("b_ready1", m_axi_bready, 1'b1);
    s_bready = 2'b01;
    #1;
    chk("b_ready1_low", m_axi_bready, 1'b0);
    m_axi_bid = 5'h03;
    #1;
    chk("b_valid0", s_bvalid,     2'b01);
    chk("b_ready0", m_axi_bready, 1'b1);
    m_axi_bvalid = 1'b0;
    s_bready     = 2'b00;

    // ---- contention from reset: grants 0,1,0,1 ----
    rst = 1'b1;
    #1;
    rst = 1'b0;
    s_awid          = {4'hB, 4'hA};
    s_awaddr        = {32'h0000_5000, 32'h0000_4000};
    s_awlen         = {8'd1, 8'd1};
    s_awvalid       = 2'b11;
    s_wvalid        = 2'b11;
    s_wlast         = 2'b00;
    m_axi_awready   = 1'b1;
    m_axi_wready    = 1'b1;
    for (int n = 0; n < 4; n++) begin
      g = n % 2;
      exp_id = {n[0], (n[0] ? 4'hB : 4'hA)};
      #1;
      chk("c_dead_cycle", busy, 1'b0);
      tick();
      #1;
      chk("c_grant", grant_idx,  n[0]);
      chk("c_awid",  m_axi_awid, exp_id);
      for (int beat = 0; beat < 2; beat++) begin
        s_wlast = (beat == 1) ? (2'b01 << g) : 2'b00;
        #1;
        chk("c_wready", s_wready, (2'b01 << g));
        tick();
      end
      s_wlast = 2'b00;
    end

    // ---- async reset at beat 2 of 4 ----
    s_awvalid     = 2'b01;
    s_awlen[7:0]  = 8'd3;
    s_wvalid      = 2'b01;
    m_axi_awready = 1'b0;
    tick();
    #1;
    chk("r_grant", grant_idx, 1'b0);
    repeat (2) tick();
    #1;
    chk("r_pre_wvalid",  m_axi_wvalid,  1'b1);
    chk("r_pre_awvalid", m_axi_awvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("r_wvalid",  m_axi_wvalid,  1'b0);
    chk("r_awvalid", m_axi_awvalid, 1'b0);
    chk("r_wready",  s_wready,      2'b00);
    chk("r_awready", s_awready,     2'b00);
    chk("r_busy",    busy,          1'b0);
    rst       = 1'b0;
    s_awvalid = 2'b11;
    tick();
    #1;
    chk("r_regrant",  grant_idx, 1'b0);
    chk("r_reg_busy", busy,      1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
